cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Synthesisable run controller for the pipelined CPU. Sits between the top-level clk/reset
//  and the CPU: stretches reset, counts cycles, watches MemBus for a to-host write that ends
//  the run (pass/fail), enforces a timeout, and keeps a circular trace of the last stores.
//  Used under the simulation bench and on the FPGA top.
// PARAMETERS
//  ADDR_W          32            MemBus address width
//  DATA_W          32            MemBus data width
//  RESET_CYCLES    4             cycles cpu_reset stays high after reset falls (>=1)
//  TIMEOUT_CYCLES  100000        RUN cycles before TIMEOUT (>=2)
//  TOHOST_ADDR     32'h4000_0010 store to this address ends the run
//  PASS_CODE       32'h0000_0001 to-host data meaning pass; any other value is fail
//  TRACE_DEPTH     8             store-trace entries (power of 2, >=2)
//  HALT_ON_DONE    1             1: re-assert cpu_reset in DONE states; 0: leave CPU running
// PORTS
//  clk               in   1                 system clock, all logic on rising edge
//  reset             in   1                 synchronous, active-high
//  MemBus_Address    in   ADDR_W            CPU bus address
//  MemBus_Write_Data in   DATA_W            CPU store data
//  MemRead           in   1                 CPU load strobe
//  MemWrite          in   1                 CPU store strobe
//  cpu_reset         out  1                 reset to the CPU
//  running           out  1                 1 in RUN
//  done              out  1                 1 in any DONE state (sticky)
//  pass              out  1                 1 only in DONE_PASS
//  timeout           out  1                 1 only in DONE_TIMEOUT
//  result_data       out  DATA_W            data of the terminating to-host store
//  cycle_count       out  32                RUN cycles elapsed, saturating
//  load_count        out  32                MemRead cycles in RUN, saturating
//  store_count       out  32                MemWrite cycles in RUN, saturating
//  trace_idx         in   $clog2(TRACE_DEPTH)  trace read index, 0 = oldest valid entry
//  trace_addr        out  ADDR_W            address at trace_idx (combinational read)
//  trace_data        out  DATA_W            data at trace_idx (combinational read)
//  trace_fill        out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
// BEHAVIOUR
//  - reset=1 (any state, any cycle): state<=HOLD, cpu_reset=1, all counters, result_data,
//    trace pointer and trace_fill <= 0; running/done/pass/timeout = 0.
//  - States: HOLD, RUN, DONE_PASS, DONE_FAIL, DONE_TIMEOUT. Outputs are decoded from state.
//  - HOLD: hold counter counts edges after reset falls; after RESET_CYCLES edges -> RUN.
//    cpu_reset is high for exactly RESET_CYCLES cycles after the last reset=1 cycle.
//  - RUN: cpu_reset=0. cycle_count +1 per cycle. load_count +1 if MemRead; store_count +1
//    if MemWrite. All three saturate at 32'hFFFF_FFFF.
//  - Every MemWrite in RUN, including the terminating one, writes {addr,data} at wr_ptr.
//    wr_ptr wraps modulo TRACE_DEPTH and the oldest entry is overwritten.
//    Read slot = (wr_ptr - trace_fill + trace_idx) mod TRACE_DEPTH.
//    If trace_idx >= trace_fill, trace_addr and trace_data read 0.
//  - Termination in RUN, evaluated on the same edge:
//    a) MemWrite && MemBus_Address==TOHOST_ADDR: result_data<=data; ->DONE_PASS if data==PASS_CODE, else ->DONE_FAIL.
//    b) else if cycle_count==TIMEOUT_CYCLES-1: ->DONE_TIMEOUT, result_data unchanged.
//    If both fall on the same cycle, the to-host store wins.
//  - DONE_*: sticky until reset. Counters, trace and result_data are frozen.
//    cpu_reset = HALT_ON_DONE. Bus activity is ignored.
//  - MemRead and MemWrite both high: each counts in its own counter; only the store is traced.
// STRUCTURE
//  - Package cpu_run_pkg: state enum (3-bit encoding), default TOHOST_ADDR and PASS_CODE constants.
//  - Sub-module run_trace_buffer: TRACE_DEPTH x (ADDR_W+DATA_W) circular RAM with wr_ptr,
//    fill count and relative-index read port.
//  - Top holds the FSM, saturating counters and output decode.
// TESTING
//  1 reset 3 cycles, RESET_CYCLES=4 -> cpu_reset high through the 4th edge after reset falls;
//    running=1 on the 5th.
//  2 store 0x1 to 0x40000010 at RUN cycle 10 -> DONE_PASS, pass=1, result_data=1,
//    cycle_count=10, store_count=1.
//  3 store 0xDEAD to TOHOST -> DONE_FAIL, pass=0, done=1, result_data=0xDEAD;
//    HALT_ON_DONE=1 -> cpu_reset=1.
//  4 TIMEOUT_CYCLES=50, no store -> timeout=1 after 50 RUN cycles; a PASS store on cycle 49
//    instead -> DONE_PASS.
//  5 TRACE_DEPTH=8, 11 stores to 0x100+4i -> trace_fill=8, trace_idx=0 gives addr 0x10C,
//    trace_idx=7 gives 0x128.
//  6 reset pulsed mid-RUN (cycle 20) -> counters and trace cleared, HOLD re-entered,
//    cpu_reset high for 4 cycles again.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run controller: FSM state encoding,
// default to-host address / pass code and saturating-counter helpers.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_HOLD         = 3'd0,
        ST_RUN          = 3'd1,
        ST_DONE_PASS    = 3'd2,
        ST_DONE_FAIL    = 3'd3,
        ST_DONE_TIMEOUT = 3'd4
    } run_state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h4000_0010;
    localparam logic [31:0] DEFAULT_PASS_CODE   = 32'h0000_0001;
    localparam logic [31:0] CNT_MAX             = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    function automatic logic is_done(input run_state_e s);
        return (s == ST_DONE_PASS) || (s == ST_DONE_FAIL) || (s == ST_DONE_TIMEOUT);
    endfunction

endpackage

// File: rtl/run_trace_buffer.sv
// Circular store trace: keeps the last DEPTH {addr,data} pairs and reads them
// back by position relative to the oldest valid entry.
module run_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [PTR_W-1:0]  i_idx,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [PTR_W:0]    o_fill
);

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_fill;
    logic [PTR_W-1:0]  w_rd_slot;
    logic              w_hit;

    // Write pointer and fill level; fill saturates once the ring is full.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_fill   <= {(PTR_W+1){1'b0}};
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            if (r_fill != (PTR_W+1)'(DEPTH)) begin
                r_fill <= r_fill + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                r_fill <= r_fill;
            end
        end else begin
            r_wr_ptr <= r_wr_ptr;
            r_fill   <= r_fill;
        end
    end

    // Storage array; stale contents are masked by the fill check on read.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_addr_mem[r_wr_ptr] <= i_addr;
            r_data_mem[r_wr_ptr] <= i_data;
        end
    end

    // When full, the low fill bits are zero so the oldest entry sits at wr_ptr.
    assign w_rd_slot = r_wr_ptr - r_fill[PTR_W-1:0] + i_idx;
    assign w_hit     = ({1'b0, i_idx} < r_fill);

    // Relative-index read port, zero outside the valid window.
    always_comb begin
        o_addr = {ADDR_W{1'b0}};
        o_data = {DATA_W{1'b0}};
        if (w_hit) begin
            o_addr = r_addr_mem[w_rd_slot];
            o_data = r_data_mem[w_rd_slot];
        end else begin
            o_addr = {ADDR_W{1'b0}};
            o_data = {DATA_W{1'b0}};
        end
    end

    assign o_fill = r_fill;

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined CPU: reset stretch, run/done FSM with
// to-host pass/fail detection, timeout, saturating activity counters and store trace.
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
    parameter logic [DATA_W-1:0] PASS_CODE      = DATA_W'(DEFAULT_PASS_CODE),
    parameter int                TRACE_DEPTH    = 8,
    parameter int                HALT_ON_DONE   = 1,
    localparam int               IDX_W          = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] MemBus_Address,
    input  logic [DATA_W-1:0] MemBus_Write_Data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] result_data,
    output logic [31:0]       cycle_count,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count,
    input  logic [IDX_W-1:0]  trace_idx,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [IDX_W:0]    trace_fill
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    run_state_e        r_state;
    run_state_e        w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_in_run;
    logic              w_tohost;
    logic              w_timeout_hit;
    logic              w_halt;

    assign w_in_run      = (r_state == ST_RUN);
    assign w_tohost      = MemWrite && (MemBus_Address == TOHOST_ADDR);
    assign w_timeout_hit = (cycle_count == 32'(TIMEOUT_CYCLES - 1));
    assign w_halt        = (HALT_ON_DONE != 0);

    // Next-state logic; a to-host store beats a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (w_tohost) begin
                    w_state_nxt = (MemBus_Write_Data == PASS_CODE) ? ST_DONE_PASS : ST_DONE_FAIL;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_DONE_TIMEOUT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE_PASS, ST_DONE_FAIL, ST_DONE_TIMEOUT: w_state_nxt = r_state;
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    // FSM state, counters, result capture and registered status decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= {HOLD_W{1'b0}};
            cycle_count <= 32'd0;
            load_count  <= 32'd0;
            store_count <= 32'd0;
            result_data <= {DATA_W{1'b0}};
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= (r_state == ST_HOLD) ? r_hold_cnt + HOLD_W'(1) : {HOLD_W{1'b0}};
            cycle_count <= sat_inc(cycle_count, w_in_run);
            load_count  <= sat_inc(load_count, w_in_run && MemRead);
            store_count <= sat_inc(store_count, w_in_run && MemWrite);
            if (w_in_run && w_tohost) begin
                result_data <= MemBus_Write_Data;
            end else begin
                result_data <= result_data;
            end
            cpu_reset   <= (w_state_nxt == ST_HOLD) || (is_done(w_state_nxt) && w_halt);
            running     <= (w_state_nxt == ST_RUN);
            done        <= is_done(w_state_nxt);
            pass        <= (w_state_nxt == ST_DONE_PASS);
            timeout     <= (w_state_nxt == ST_DONE_TIMEOUT);
        end
    end

    run_trace_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .i_clk   (clk),
        .i_reset (reset),
        .i_wr_en (w_in_run && MemWrite),
        .i_addr  (MemBus_Address),
        .i_data  (MemBus_Write_Data),
        .i_idx   (trace_idx),
        .o_addr  (trace_addr),
        .o_data  (trace_data),
        .o_fill  (trace_fill)
    );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized and directed bench for cpu_run_controller, checked every cycle
// against a behavioural model built from hold/run cycle counts and a trace queue.
module tb_cpu_run_controller;

    localparam int          RC     = 4;
    localparam int          TO     = 50;
    localparam int          TD     = 8;
    localparam logic [31:0] TOHOST = 32'h4000_0010;
    localparam logic [31:0] PCODE  = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite;
    logic [31:0] MemBus_Address, MemBus_Write_Data;
    logic        cpu_reset, running, done, pass, timeout;
    logic [31:0] result_data, cycle_count, load_count, store_count;
    logic [2:0]  trace_idx;
    logic [31:0] trace_addr, trace_data;
    logic [3:0]  trace_fill;

    cpu_run_controller #(
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO),
        .TRACE_DEPTH    (TD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .MemBus_Address    (MemBus_Address),
        .MemBus_Write_Data (MemBus_Write_Data),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .cpu_reset         (cpu_reset),
        .running           (running),
        .done              (done),
        .pass              (pass),
        .timeout           (timeout),
        .result_data       (result_data),
        .cycle_count       (cycle_count),
        .load_count        (load_count),
        .store_count       (store_count),
        .trace_idx         (trace_idx),
        .trace_addr        (trace_addr),
        .trace_data        (trace_data),
        .trace_fill        (trace_fill)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles of reset stretch left, run flag, outcome kind
    // (0 none, 1 pass, 2 fail, 3 timeout), counts and the last TD stores.
    int          m_hold_left;
    bit          m_run;
    int          m_kind;
    logic [31:0] m_cycles, m_loads, m_stores, m_result;
    logic [63:0] m_trace[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_update(input logic rst, input logic rd, input logic wr,
                                         input logic [31:0] a, input logic [31:0] d);
        if (rst) begin
            m_hold_left = RC;
            m_run       = 1'b0;
            m_kind      = 0;
            m_cycles    = 32'd0;
            m_loads     = 32'd0;
            m_stores    = 32'd0;
            m_result    = 32'd0;
            m_trace.delete();
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_run = 1'b1;
        end else if (m_run) begin
            m_cycles++;
            if (rd) m_loads++;
            if (wr) begin
                m_stores++;
                m_trace.push_back({a, d});
                if (m_trace.size() > TD) void'(m_trace.pop_front());
            end
            if (wr && a == TOHOST) begin
                m_result = d;
                m_kind   = (d == PCODE) ? 1 : 2;
                m_run    = 1'b0;
            end else if (m_cycles == TO) begin
                m_kind = 3;
                m_run  = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        logic [2:0]  idx;
        logic [63:0] e;
        idx = 3'($urandom_range(0, 7));
        trace_idx = idx;
        #1;
        chk("cpu_reset", cpu_reset, (m_hold_left > 0) || (m_kind != 0));
        chk("running", running, m_run);
        chk("done", done, m_kind != 0);
        chk("pass", pass, m_kind == 1);
        chk("timeout", timeout, m_kind == 3);
        chk("result_data", result_data, m_result);
        chk("cycle_count", cycle_count, m_cycles);
        chk("load_count", load_count, m_loads);
        chk("store_count", store_count, m_stores);
        chk("trace_fill", trace_fill, m_trace.size());
        e = (int'(idx) < m_trace.size()) ? m_trace[idx] : 64'd0;
        chk("trace_addr", trace_addr, e[63:32]);
        chk("trace_data", trace_data, e[31:0]);
    endtask

    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        reset = rst; MemRead = rd; MemWrite = wr; MemBus_Address = a; MemBus_Write_Data = d;
        @(posedge clk);
        model_update(rst, rd, wr, a, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        trace_idx = 3'd0;
        // Reset stretch: high for RC cycles, RUN on the next one.
        do_reset(3);
        chk("t1_cnt_rst", cycle_count, 32'd0);
        idle(RC - 1);
        chk("t1_hold", cpu_reset, 1'b1);
        idle(1);
        chk("t1_run", running, 1'b1);
        chk("t1_crst_low", cpu_reset, 1'b0);

        // PASS store on RUN cycle 10.
        idle(9);
        step(1'b0, 1'b0, 1'b1, TOHOST, PCODE);
        chk("t2_pass", pass, 1'b1);
        chk("t2_res", result_data, 32'd1);
        chk("t2_cc", cycle_count, 32'd10);
        chk("t2_sc", store_count, 32'd1);
        idle(3);

        // FAIL code; CPU held in reset afterwards; later bus traffic ignored.
        do_reset(2); idle(RC + 2);
        step(1'b0, 1'b1, 1'b1, TOHOST, 32'h0000_DEAD);
        chk("t3_done", done, 1'b1);
        chk("t3_pass", pass, 1'b0);
        chk("t3_res", result_data, 32'h0000_DEAD);
        chk("t3_halt", cpu_reset, 1'b1);
        step(1'b0, 1'b1, 1'b1, TOHOST, PCODE);
        chk("t3_sticky", pass, 1'b0);

        // Timeout after TO idle RUN cycles, then a PASS on the very last cycle.
        do_reset(1); idle(RC + TO - 1);
        chk("t4_not_yet", timeout, 1'b0);
        idle(1);
        chk("t4_to", timeout, 1'b1);
        chk("t4_cc", cycle_count, 32'd50);
        do_reset(1); idle(RC + TO - 1);
        step(1'b0, 1'b0, 1'b1, TOHOST, PCODE);
        chk("t4b_pass", pass, 1'b1);
        chk("t4b_to", timeout, 1'b0);

        // Trace wrap: 11 stores, oldest kept is the 4th.
        do_reset(1); idle(RC);
        for (int i = 0; i < 11; i++)
            step(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'(i));
        trace_idx = 3'd0; #1;
        chk("t5_fill", trace_fill, 4'd8);
        chk("t5_idx0", trace_addr, 32'h10C);
        trace_idx = 3'd7; #1;
        chk("t5_idx7", trace_addr, 32'h128);

        // Reset mid-run.
        do_reset(1); idle(RC + 19);
        step(1'b0, 1'b1, 1'b1, 32'h200, 32'h5);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t6_cc", cycle_count, 32'd0);
        chk("t6_fill", trace_fill, 4'd0);
        idle(RC - 1);
        chk("t6_hold", cpu_reset, 1'b1);
        idle(1);
        chk("t6_run", running, 1'b1);

        // Random runs against the model.
        for (int r = 0; r < 25; r++) begin
            int len;
            do_reset($urandom_range(1, 3));
            len = $urandom_range(10, 70);
            for (int c = 0; c < len; c++) begin
                logic        rd, wr, rst;
                logic [31:0] a, d;
                rst = ($urandom % 150) == 0;
                rd  = $urandom % 2;
                wr  = ($urandom % 3) == 0;
                a   = (($urandom % 10) == 0) ? TOHOST : (32'h100 + ($urandom & 32'h0000_00FC));
                d   = (($urandom % 2) == 0) ? PCODE : $urandom;
                step(rst, rd, wr, a, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
